smlsib_key_ctrl: RTL and testbench

Key-attempt controller for the key-locked segment-insertion bit (SIB). It owns a scan-accessible key shift register on the IJTAG path and sequences compare, unlock and relock. It rate-limits guessing with a failed-attempt counter and a timed lockout. Its KeyValid output drives the SIB's compare-result input, replacing a free-running combinational compare.

---
 rtl/smlsib_pkg.sv | 24 ++
 rtl/smlsib_key_ctrl_comp.sv | 15 +
 rtl/smlsib_key_ctrl.sv | 159 +++++++++++++++
 tb/tb_smlsib_key_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smlsib_pkg.sv
// Shared definitions for the key-locked SIB controller: state encoding,
// capture-pattern bit positions and a constant clog2 helper.
package smlsib_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_CHECK    = 2'd1;
   localparam state_t ST_UNLOCKED = 2'd2;
   localparam state_t ST_LOCKOUT  = 2'd3;

   localparam int CAP_KEYVALID = 0;
   localparam int CAP_LOCKED   = 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/smlsib_key_ctrl_comp.sv
// Parameterized full-width equality comparator; the result is registered
// by the key controller FSM, never used combinationally on an output.
module Comp
   import smlsib_pkg::*;
#(
   parameter int Length = 128
) (
   input  logic [Length-1:0] A,
   input  logic [Length-1:0] B,
   output logic              Match
);

   assign Match = (A == B);

endmodule

// File: rtl/smlsib_key_ctrl.sv
// Key-attempt controller for the key-locked SIB: scan key register,
// compare/unlock/relock sequencing, failure counting and timed lockout.
module smlsib_key_ctrl
   import smlsib_pkg::*;
#(
   parameter int                Length     = 128,
   parameter logic [Length-1:0] KeyValue   = Length'(3476123),
   parameter int                MaxFail    = 3,
   parameter int                LockCycles = 1024
) (
   input  logic                            Clock,
   input  logic                            Rst,
   input  logic                            SI,
   input  logic                            ShiftEN,
   input  logic                            CaptureEN,
   input  logic                            UpdateEn,
   input  logic                            Select,
   input  logic                            Relock,
   output logic                            SO,
   output logic                            KeyValid,
   output logic                            Locked,
   output logic [clog2(MaxFail+1)-1:0]     FailCount
);

   localparam int FW = clog2(MaxFail + 1);
   localparam int TW = (LockCycles > 1) ? clog2(LockCycles) : 1;

   localparam logic [FW-1:0] FAIL_MAX   = FW'(MaxFail);
   localparam logic [FW-1:0] FAIL_REARM = FW'(MaxFail - 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(LockCycles - 1);

   state_t            state_q, state_d;
   logic [Length-1:0] kreg_q, kreg_d;
   logic [FW-1:0]     fail_q, fail_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              keyvalid_q, keyvalid_d;
   logic              locked_q, locked_d;

   logic              key_match;
   logic              do_update, do_capture, do_shift;
   logic [FW-1:0]     fail_inc;
   logic [Length-1:0] cap_pat;

   Comp #(.Length(Length)) u_comp (
      .A     (kreg_q),
      .B     (KeyValue),
      .Match (key_match)
   );

   // One IJTAG op per cycle, Update highest; the one-cycle CHECK window freezes kreg.
   always_comb begin
      do_update  = 1'b0;
      do_capture = 1'b0;
      do_shift   = 1'b0;
      if (Select && (state_q != ST_CHECK)) begin
         if (UpdateEn) begin
            do_update = 1'b1;
         end else if (CaptureEN) begin
            do_capture = 1'b1;
         end else if (ShiftEN) begin
            do_shift = 1'b1;
         end
      end
   end

   always_comb begin
      cap_pat               = '0;
      cap_pat[CAP_KEYVALID] = keyvalid_q;
      cap_pat[CAP_LOCKED]   = locked_q;
   end

   always_comb begin
      kreg_d = kreg_q;
      if (do_capture) begin
         kreg_d = cap_pat;
      end else if (do_shift) begin
         kreg_d = {SI, kreg_q[Length-1:1]};
      end
   end

   assign fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + FW'(1);

   always_comb begin
      state_d    = state_q;
      fail_d     = fail_q;
      timer_d    = timer_q;
      keyvalid_d = keyvalid_q;
      locked_d   = locked_q;
      case (state_q)
         ST_IDLE: begin
            if (do_update) begin
               state_d = ST_CHECK;
            end
         end
         ST_UNLOCKED: begin
            if (Relock) begin
               state_d    = ST_IDLE;
               keyvalid_d = 1'b0;
            end else if (do_update) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (key_match) begin
               state_d    = ST_UNLOCKED;
               keyvalid_d = 1'b1;
               fail_d     = '0;
            end else begin
               keyvalid_d = 1'b0;
               fail_d     = fail_inc;
               if (fail_inc == FAIL_MAX) begin
                  state_d  = ST_LOCKOUT;
                  locked_d = 1'b1;
                  timer_d  = TIMER_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_LOCKOUT: begin
            // Leaving one short of MaxFail means a single further miss relocks.
            if (timer_q == '0) begin
               state_d  = ST_IDLE;
               locked_d = 1'b0;
               fail_d   = FAIL_REARM;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state_q    <= ST_IDLE;
         kreg_q     <= '0;
         fail_q     <= '0;
         timer_q    <= '0;
         keyvalid_q <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         kreg_q     <= kreg_d;
         fail_q     <= fail_d;
         timer_q    <= timer_d;
         keyvalid_q <= keyvalid_d;
         locked_q   <= locked_d;
      end
   end

   assign SO        = kreg_q[0];
   assign KeyValid  = keyvalid_q;
   assign Locked    = locked_q;
   assign FailCount = fail_q;

endmodule

// File: tb/tb_smlsib_key_ctrl.sv
// Self-checking bench for smlsib_key_ctrl (Length=8, key 8'hA5, MaxFail=3,
// LockCycles=16): vector table plus hand-written multi-cycle sequences.
module tb_smlsib_key_ctrl;

   logic       Clock = 1'b0;
   logic       Rst, SI, ShiftEN, CaptureEN, UpdateEn, Select, Relock;
   logic       SO, KeyValid, Locked;
   logic [1:0] FailCount;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      name;
      logic       kv;
      logic       lk;
      logic [1:0] fc;
   } exp_t;

   typedef struct {
      logic [7:0] key;
      logic       kv;
      logic [1:0] fc;
   } vec_t;

   exp_t       sb_q[$];
   vec_t       vecs[6];
   logic [7:0] rd;

   smlsib_key_ctrl #(
      .Length     (8),
      .KeyValue   (8'hA5),
      .MaxFail    (3),
      .LockCycles (16)
   ) dut (
      .Clock     (Clock),
      .Rst       (Rst),
      .SI        (SI),
      .ShiftEN   (ShiftEN),
      .CaptureEN (CaptureEN),
      .UpdateEn  (UpdateEn),
      .Select    (Select),
      .Relock    (Relock),
      .SO        (SO),
      .KeyValid  (KeyValid),
      .Locked    (Locked),
      .FailCount (FailCount)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic kv, input logic lk, input logic [1:0] fc);
      check({name, ".KeyValid"},  8'(KeyValid),  8'(kv));
      check({name, ".Locked"},    8'(Locked),    8'(lk));
      check({name, ".FailCount"}, 8'(FailCount), 8'(fc));
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: actual=empty queue required=pending entry");
      end else begin
         e = sb_q.pop_front();
         check_outs(e.name, e.kv, e.lk, e.fc);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic shift_key(input logic [7:0] k);
      for (int i = 0; i < 8; i++) begin
         SI      = k[i];
         ShiftEN = 1'b1;
         tick();
      end
      ShiftEN = 1'b0;
      SI      = 1'b0;
   endtask

   task automatic pulse_update();
      UpdateEn = 1'b1;
      tick();
      UpdateEn = 1'b0;
   endtask

   task automatic read_kreg(output logic [7:0] v);
      CaptureEN = 1'b1;
      tick();
      CaptureEN = 1'b0;
      for (int i = 0; i < 8; i++) begin
         v[i]    = SO;
         SI      = 1'b0;
         ShiftEN = 1'b1;
         tick();
      end
      ShiftEN = 1'b0;
   endtask

   // Load a key, update, and compare once KeyValid/Locked are due (second edge).
   task automatic try_key(input string name, input logic [7:0] k, input logic kv,
                          input logic lk, input logic [1:0] fc);
      shift_key(k);
      sb_q.push_back('{name, kv, lk, fc});
      pulse_update();
      tick();
      sb_check();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Rst = 1'b1; SI = 1'b0; ShiftEN = 1'b0; CaptureEN = 1'b0;
      UpdateEn = 1'b0; Select = 1'b1; Relock = 1'b0;

      vecs[0] = '{key: 8'h00, kv: 1'b0, fc: 2'd1};
      vecs[1] = '{key: 8'h3C, kv: 1'b0, fc: 2'd2};
      vecs[2] = '{key: 8'hA5, kv: 1'b1, fc: 2'd0};
      vecs[3] = '{key: 8'hA4, kv: 1'b0, fc: 2'd1};
      vecs[4] = '{key: 8'h5A, kv: 1'b0, fc: 2'd2};
      vecs[5] = '{key: 8'hA5, kv: 1'b1, fc: 2'd0};

      repeat (2) tick();
      Rst = 1'b0;
      tick();

      // Reset asserted mid-shift clears everything without an edge
      SI = 1'b1; ShiftEN = 1'b1;
      repeat (8) tick();
      check("shift_ones.SO", 8'(SO), 8'h01);
      #2 Rst = 1'b1;
      #1;
      check_outs("rst_midshift", 1'b0, 1'b0, 2'd0);
      check("rst_midshift.SO", 8'(SO), 8'h00);
      ShiftEN = 1'b0; SI = 1'b0;
      tick();
      Rst = 1'b0;
      read_kreg(rd);
      check("capture_after_reset", rd, 8'h00);
      check_outs("after_reset", 1'b0, 1'b0, 2'd0);

      // Correct key with latency check
      shift_key(8'hA5);
      pulse_update();
      check_outs("check_cycle", 1'b0, 1'b0, 2'd0);
      tick();
      check_outs("unlock", 1'b1, 1'b0, 2'd0);
      read_kreg(rd);
      check("capture_unlocked", rd, 8'h01);

      for (int i = 0; i < 6; i++) begin
         try_key($sformatf("vec%0d", i), vecs[i].key, vecs[i].kv, 1'b0, vecs[i].fc);
      end

      // Relock pulse, then unlock and re-check with a wrong key
      Relock = 1'b1;
      tick();
      Relock = 1'b0;
      check_outs("relock", 1'b0, 1'b0, 2'd0);
      try_key("reunlock", 8'hA5, 1'b1, 1'b0, 2'd0);
      try_key("recheck_wrong", 8'hA4, 1'b0, 1'b0, 2'd1);

      // Update beats Shift in the same cycle
      shift_key(8'hA5);
      sb_q.push_back('{"upd_over_shift", 1'b1, 1'b0, 2'd0});
      UpdateEn = 1'b1; ShiftEN = 1'b1; SI = 1'b0;
      tick();
      UpdateEn = 1'b0; ShiftEN = 1'b0;
      tick();
      sb_check();

      // Ops with Select=0 leave kreg and state alone
      Select = 1'b0; SI = 1'b1;
      ShiftEN = 1'b1; tick(); ShiftEN = 1'b0;
      CaptureEN = 1'b1; tick(); CaptureEN = 1'b0;
      UpdateEn = 1'b1; tick(); UpdateEn = 1'b0;
      tick();
      Select = 1'b1; SI = 1'b0;
      check_outs("sel0_hold", 1'b1, 1'b0, 2'd0);
      sb_q.push_back('{"sel0_kreg", 1'b1, 1'b0, 2'd0});
      pulse_update();
      tick();
      sb_check();

      // Update + Relock in UNLOCKED: relock, no compare
      shift_key(8'h00);
      UpdateEn = 1'b1; Relock = 1'b1;
      tick();
      UpdateEn = 1'b0; Relock = 1'b0;
      check_outs("upd_relock", 1'b0, 1'b0, 2'd0);
      tick();
      check_outs("upd_relock_nocmp", 1'b0, 1'b0, 2'd0);

      // Three failures trigger lockout
      for (int k = 1; k <= 3; k++) begin
         sb_q.push_back('{$sformatf("fail%0d", k), 1'b0, (k == 3), 2'(k)});
         pulse_update();
         tick();
         sb_check();
      end

      // Lockout entered at edge e; release is due at edge e+16
      shift_key(8'hA5);
      pulse_update();
      tick();
      check_outs("lock_upd_ignored", 1'b0, 1'b1, 2'd3);
      repeat (5) tick();
      check_outs("lock_last_cycle", 1'b0, 1'b1, 2'd3);
      tick();
      check_outs("lock_release", 1'b0, 1'b0, 2'd2);

      try_key("relock_immediate", 8'h00, 1'b0, 1'b1, 2'd3);

      // Async reset in the middle of the lockout timer
      repeat (3) tick();
      check_outs("lock_before_rst", 1'b0, 1'b1, 2'd3);
      #2 Rst = 1'b1;
      #1;
      check_outs("async_rst_lockout", 1'b0, 1'b0, 2'd0);
      tick();
      Rst = 1'b0;
      tick();
      check_outs("post_rst", 1'b0, 1'b0, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
